// File: rtl/ising_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ising_pkg
// Description : Shared types and width helpers for the Ising field scheduler.
//               Provides the sequencer state enum and the width functions
//               used to size h_c, the energy accumulator and column addresses.
// Revision    : 1.0 - initial release
// ============================================================================
package ising_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_CAPT  = 2'd2,
        ST_EMIT  = 2'd3
    } state_e;

    // Signed width of one local field: J magnitude + sign bit + growth of the tree.
    function automatic int result_width(input int vector_size, input int j_width);
        return j_width + 1 + $clog2(vector_size);
    endfunction

    // Signed width of the energy sum over all columns, with one bit of headroom.
    function automatic int energy_width(input int res_width, input int num_cols);
        return res_width + $clog2(num_cols) + 1;
    endfunction

    // max(1, $clog2(n)): a single column still needs a one-bit address port.
    function automatic int addr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : ising_pkg
`default_nettype wire

// File: rtl/ising_field_scheduler_dot_product_tree.sv
`default_nettype none
// ============================================================================
// Module      : dot_product_tree
// Description : Combinational signed adder tree computing
//               sum_k (sigma[k] ? +J[k] : -J[k]) over one coupling column.
// Ports       : sigma_i  - spin vector, one bit per tree leaf
//               j_col_i  - unsigned J magnitudes, one per leaf
//               result_o - signed sum, RESULT_WIDTH bits
// Revision    : 1.0 - initial release
// ============================================================================
module dot_product_tree #(
    parameter int VECTOR_SIZE     = 256,
    parameter int J_ELEMENT_WIDTH = 4,
    parameter int RESULT_WIDTH    = J_ELEMENT_WIDTH + 1 + $clog2(VECTOR_SIZE)
) (
    input  logic [VECTOR_SIZE-1:0]     sigma_i,
    input  logic [J_ELEMENT_WIDTH-1:0] j_col_i [VECTOR_SIZE],
    output logic signed [RESULT_WIDTH-1:0] result_o
);

    localparam int LEVELS = $clog2(VECTOR_SIZE);

    // Level 0 holds the signed leaf terms; level l holds VECTOR_SIZE>>l partial
    // sums. RESULT_WIDTH already covers the full growth, so every level uses it.
    for (genvar l = 0; l <= LEVELS; l++) begin : g_level
        localparam int NODES = VECTOR_SIZE >> l;
        logic signed [RESULT_WIDTH-1:0] sum [NODES];

        if (l == 0) begin : g_leaf
            for (genvar k = 0; k < NODES; k++) begin : g_term
                logic signed [RESULT_WIDTH-1:0] mag;
                assign mag    = {{(RESULT_WIDTH-J_ELEMENT_WIDTH){1'b0}}, j_col_i[k]};
                assign sum[k] = sigma_i[k] ? mag : -mag;
            end
        end else begin : g_add
            for (genvar k = 0; k < NODES; k++) begin : g_node
                assign sum[k] = g_level[l-1].sum[2*k] + g_level[l-1].sum[2*k+1];
            end
        end
    end

    assign result_o = g_level[LEVELS].sum[0];

endmodule : dot_product_tree
`default_nettype wire

// File: rtl/ising_field_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : ising_field_scheduler
// Description : Walks every column of the coupling memory, computes the local
//               field h_c of each column with one dot-product tree, streams
//               (c, h_c) on a valid/ready port and accumulates the energy
//               E = sum_c (sigma_c ? +h_c : -h_c).
// Ports       : clk_i/rst_ni         - clock, async active-low reset
//               start_i/abort_i      - run control (abort has priority)
//               sigma_i              - spin vector, latched on start
//               busy_o/done_o        - run status, done is a 1-cycle pulse
//               energy_o             - energy of the last completed run
//               mem_req_o/mem_addr_o - column read, data one cycle later
//               mem_rdata_i          - J column, element k at [k*Jw +: Jw]
//               res_*                - h_c result stream with column index
// Revision    : 1.0 - initial release
// ============================================================================
module ising_field_scheduler
    import ising_pkg::*;
#(
    parameter int VECTOR_SIZE     = 256,
    parameter int J_ELEMENT_WIDTH = 4,
    parameter int NUM_COLS        = 256,
    parameter int RESULT_WIDTH    = result_width(VECTOR_SIZE, J_ELEMENT_WIDTH),
    parameter int ENERGY_WIDTH    = energy_width(RESULT_WIDTH, NUM_COLS)
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic                                     start_i,
    input  logic                                     abort_i,
    input  logic [VECTOR_SIZE-1:0]                   sigma_i,
    output logic                                     busy_o,
    output logic                                     done_o,
    output logic signed [ENERGY_WIDTH-1:0]           energy_o,
    output logic                                     mem_req_o,
    output logic [addr_width(NUM_COLS)-1:0]          mem_addr_o,
    input  logic [VECTOR_SIZE*J_ELEMENT_WIDTH-1:0]   mem_rdata_i,
    output logic                                     res_valid_o,
    input  logic                                     res_ready_i,
    output logic signed [RESULT_WIDTH-1:0]           res_data_o,
    output logic [addr_width(NUM_COLS)-1:0]          res_idx_o
);

    localparam int                AW       = addr_width(NUM_COLS);
    localparam logic [AW-1:0]     LAST_COL = AW'(NUM_COLS - 1);

    state_e                          state_q, state_d;
    logic [VECTOR_SIZE-1:0]          sigma_q, sigma_d;
    logic [AW-1:0]                   cnt_q, cnt_d;
    logic signed [RESULT_WIDTH-1:0]  res_data_q, res_data_d;
    logic [AW-1:0]                   res_idx_q, res_idx_d;
    logic signed [ENERGY_WIDTH-1:0]  acc_q, acc_d;
    logic signed [ENERGY_WIDTH-1:0]  energy_q, energy_d;
    logic                            done_q, done_d;

    logic [J_ELEMENT_WIDTH-1:0]      j_col [VECTOR_SIZE];
    logic signed [RESULT_WIDTH-1:0]  tree_result;
    logic signed [ENERGY_WIDTH-1:0]  h_ext;

    for (genvar k = 0; k < VECTOR_SIZE; k++) begin : g_unpack
        assign j_col[k] = mem_rdata_i[k*J_ELEMENT_WIDTH +: J_ELEMENT_WIDTH];
    end

    dot_product_tree #(
        .VECTOR_SIZE     (VECTOR_SIZE),
        .J_ELEMENT_WIDTH (J_ELEMENT_WIDTH),
        .RESULT_WIDTH    (RESULT_WIDTH)
    ) u_dot_product_tree (
        .sigma_i  (sigma_q),
        .j_col_i  (j_col),
        .result_o (tree_result)
    );

    assign h_ext = {{(ENERGY_WIDTH-RESULT_WIDTH){tree_result[RESULT_WIDTH-1]}}, tree_result};

    always_comb begin
        state_d    = state_q;
        sigma_d    = sigma_q;
        cnt_d      = cnt_q;
        res_data_d = res_data_q;
        res_idx_d  = res_idx_q;
        acc_d      = acc_q;
        energy_d   = energy_q;
        done_d     = 1'b0;

        if (abort_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        sigma_d  = sigma_i;
                        cnt_d    = '0;
                        acc_d    = '0;
                        // The published energy is cleared too, so an aborted
                        // run leaves 0 rather than a stale or partial value.
                        energy_d = '0;
                        state_d  = ST_FETCH;
                    end
                end
                ST_FETCH: state_d = ST_CAPT;
                ST_CAPT: begin
                    res_data_d = tree_result;
                    res_idx_d  = cnt_q;
                    acc_d      = sigma_q[cnt_q] ? (acc_q + h_ext) : (acc_q - h_ext);
                    state_d    = ST_EMIT;
                end
                ST_EMIT: begin
                    if (res_ready_i) begin
                        if (cnt_q == LAST_COL) begin
                            energy_d = acc_q;
                            done_d   = 1'b1;
                            state_d  = ST_IDLE;
                        end else begin
                            cnt_d   = cnt_q + AW'(1);
                            state_d = ST_FETCH;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            sigma_q    <= '0;
            cnt_q      <= '0;
            res_data_q <= '0;
            res_idx_q  <= '0;
            acc_q      <= '0;
            energy_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sigma_q    <= sigma_d;
            cnt_q      <= cnt_d;
            res_data_q <= res_data_d;
            res_idx_q  <= res_idx_d;
            acc_q      <= acc_d;
            energy_q   <= energy_d;
            done_q     <= done_d;
        end
    end

    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = done_q;
    assign energy_o    = energy_q;
    assign mem_req_o   = (state_q == ST_FETCH);
    assign mem_addr_o  = cnt_q;
    assign res_valid_o = (state_q == ST_EMIT);
    assign res_data_o  = res_data_q;
    assign res_idx_o   = res_idx_q;

endmodule : ising_field_scheduler
`default_nettype wire

// File: tb/tb_ising_field_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_ising_field_scheduler
// Description : Self-checking bench for ising_field_scheduler with a 4x4
//               coupling matrix, a one-cycle-latency column memory model and
//               a result scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ising_field_scheduler;

    localparam int VS = 4;
    localparam int JW = 4;
    localparam int NC = 4;
    localparam int RW = 7;
    localparam int EW = 10;
    localparam int AW = 2;

    logic                  clk_i       = 1'b0;
    logic                  rst_ni      = 1'b0;
    logic                  start_i     = 1'b0;
    logic                  abort_i     = 1'b0;
    logic [VS-1:0]         sigma_i     = '0;
    logic                  res_ready_i = 1'b0;
    logic [VS*JW-1:0]      mem_rdata_i = '0;
    logic                  busy_o, done_o, mem_req_o, res_valid_o;
    logic signed [EW-1:0]  energy_o;
    logic [AW-1:0]         mem_addr_o, res_idx_o;
    logic signed [RW-1:0]  res_data_o;

    ising_field_scheduler #(
        .VECTOR_SIZE     (VS),
        .J_ELEMENT_WIDTH (JW),
        .NUM_COLS        (NC)
    ) u_dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .sigma_i     (sigma_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .energy_o    (energy_o),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .mem_rdata_i (mem_rdata_i),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready_i),
        .res_data_o  (res_data_o),
        .res_idx_o   (res_idx_o)
    );

    always #5 clk_i = ~clk_i;

    // Column memory: data appears one cycle after the request.
    logic [VS*JW-1:0] mem [NC];
    always @(posedge clk_i) begin
        if (mem_req_o) mem_rdata_i <= mem[mem_addr_o];
    end

    typedef struct {
        logic [AW-1:0]        idx;
        logic signed [RW-1:0] h;
    } exp_t;

    exp_t                 exp_q[$];
    logic signed [EW-1:0] exp_energy;
    int                   checks = 0;
    int                   errors = 0;

    // Reference model: pushes every expected (idx, h) of a run and the energy.
    function automatic void push_run(input logic [VS-1:0] s);
        int   e;
        exp_t t;
        e = 0;
        for (int c = 0; c < NC; c++) begin
            int h;
            h = 0;
            for (int k = 0; k < VS; k++) begin
                int j;
                j = int'(mem[c][k*JW +: JW]);
                h = s[k] ? (h + j) : (h - j);
            end
            t.idx = AW'(c);
            t.h   = RW'(h);
            exp_q.push_back(t);
            e = s[c] ? (e + h) : (e - h);
        end
        exp_energy = EW'(e);
    endfunction

    // Scoreboard: every accepted result is compared against the model queue.
    always @(negedge clk_i) begin
        exp_t t;
        if (rst_ni && res_valid_o && res_ready_i) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result idx=%0d data=%0d required=none", res_idx_o, res_data_o);
            end else begin
                t = exp_q.pop_front();
                if (res_idx_o !== t.idx || res_data_o !== t.h) begin
                    errors++;
                    $display("FAIL result idx=%0d data=%0d required idx=%0d data=%0d",
                             res_idx_o, res_data_o, t.idx, t.h);
                end
            end
        end
    end

    task automatic fill_const(input logic [JW-1:0] v);
        for (int c = 0; c < NC; c++)
            for (int k = 0; k < VS; k++) mem[c][k*JW +: JW] = v;
    endtask

    task automatic fill_col_index();
        for (int c = 0; c < NC; c++)
            for (int k = 0; k < VS; k++) mem[c][k*JW +: JW] = JW'(c + 1);
    endtask

    // Raises start for exactly one sampling edge; returns 1 ns after it.
    task automatic kick(input logic [VS-1:0] s);
        @(posedge clk_i); #1;
        start_i = 1'b1;
        sigma_i = s;
        push_run(s);
        @(posedge clk_i); #1;
        start_i = 1'b0;
    endtask

    // Counts observed cycles after the start edge until done_o (bounded).
    task automatic wait_done(output int k);
        k = 0;
        do begin
            @(negedge clk_i);
            k++;
        end while (!done_o && k < 200);
    endtask

    task automatic check_done_energy(input string name, input int k, input int req_k,
                                     input logic signed [EW-1:0] req_e);
        checks++;
        if (!done_o) begin
            errors++;
            $display("FAIL %s_timeout done=%0b required=1", name, done_o);
        end else if (req_k > 0 && k != req_k) begin
            errors++;
            $display("FAIL %s_done_cycle got=%0d required=%0d", name, k, req_k);
        end
        checks++;
        if (energy_o !== req_e || exp_energy !== req_e) begin
            errors++;
            $display("FAIL %s_energy got=%0d model=%0d required=%0d", name, energy_o, exp_energy, req_e);
        end
        checks++;
        if (busy_o !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_end busy=%0b pending=%0d required busy=0 pending=0", name, busy_o, exp_q.size());
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({busy_o, done_o, mem_req_o, mem_addr_o, res_valid_o, res_data_o, res_idx_o, energy_o} !== '0) begin
            errors++;
            $display("FAIL %s busy=%0b done=%0b req=%0b addr=%0d valid=%0b data=%0d idx=%0d energy=%0d required all 0",
                     name, busy_o, done_o, mem_req_o, mem_addr_o, res_valid_o, res_data_o, res_idx_o, energy_o);
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check_all_zero("reset_held");
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        check_all_zero("reset_released");
    endtask

    task automatic test_all_ones();
        int k;
        fill_const(4'd15);
        res_ready_i = 1'b1;
        kick(4'b1111);
        @(negedge clk_i);
        checks++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 2'd0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL first_fetch req=%0b addr=%0d busy=%0b required 1 0 1", mem_req_o, mem_addr_o, busy_o);
        end
        wait_done(k);
        check_done_energy("all_ones", k + 1, 13, 10'sd240);
        @(negedge clk_i);
        checks++;
        if (done_o !== 1'b0 || energy_o !== 10'sd240) begin
            errors++;
            $display("FAIL done_pulse done=%0b energy=%0d required done=0 energy=240", done_o, energy_o);
        end
    endtask

    task automatic test_all_zeros();
        int k;
        fill_const(4'd15);
        kick(4'b0000);
        wait_done(k);
        check_done_energy("all_zeros", k, 13, 10'sd240);
    endtask

    task automatic test_back_to_back();
        int k;
        fill_col_index();
        kick(4'b0101);
        wait_done(k);
        check_done_energy("mixed", k, 13, 10'sd0);
        // Start sampled at the edge closing the done cycle.
        start_i = 1'b1;
        sigma_i = 4'b1111;
        push_run(4'b1111);
        @(posedge clk_i); #1;
        start_i = 1'b0;
        wait_done(k);
        check_done_energy("back_to_back", k, 13, 10'sd40);
    endtask

    task automatic test_stall();
        int                   k;
        logic signed [RW-1:0] d0;
        logic [AW-1:0]        i0;
        fill_const(4'd15);
        res_ready_i = 1'b0;
        kick(4'b1111);
        k = 0;
        do begin
            @(negedge clk_i);
            k++;
        end while (!res_valid_o && k < 20);
        checks++;
        if (k != 3 || !res_valid_o) begin
            errors++;
            $display("FAIL first_valid_cycle got=%0d required=3", k);
        end
        d0 = res_data_o;
        i0 = res_idx_o;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk_i);
            checks++;
            if (res_data_o !== d0 || res_idx_o !== i0 || mem_req_o !== 1'b0 ||
                busy_o !== 1'b1 || res_valid_o !== 1'b1 || d0 !== 7'sd60) begin
                errors++;
                $display("FAIL stall_hold data=%0d idx=%0d req=%0b busy=%0b valid=%0b required data=60 idx=%0d req=0 busy=1 valid=1",
                         res_data_o, res_idx_o, mem_req_o, busy_o, res_valid_o, i0);
            end
        end
        @(posedge clk_i); #1;
        res_ready_i = 1'b1;
        wait_done(k);
        check_done_energy("stall", k, 0, 10'sd240);
    endtask

    task automatic test_abort();
        int   k;
        logic bad;
        fill_col_index();
        res_ready_i = 1'b1;
        kick(4'b1111);
        repeat (4) @(negedge clk_i);
        @(posedge clk_i); #1;          // cycle t+5: second CAPT
        abort_i = 1'b1;
        @(posedge clk_i); #1;
        abort_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (busy_o !== 1'b0 || res_valid_o !== 1'b0 || done_o !== 1'b0 || energy_o !== 10'sd0) begin
            errors++;
            $display("FAIL abort_idle busy=%0b valid=%0b done=%0b energy=%0d required 0 0 0 0",
                     busy_o, res_valid_o, done_o, energy_o);
        end
        bad = 1'b0;
        repeat (5) begin
            @(negedge clk_i);
            if (done_o || res_valid_o) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0 || exp_q.size() != 3) begin
            errors++;
            $display("FAIL abort_quiet spurious=%0b pending=%0d required spurious=0 pending=3", bad, exp_q.size());
        end
        exp_q.delete();
        kick(4'b0111);
        wait_done(k);
        check_done_energy("after_abort", k, 13, 10'sd4);
    endtask

    task automatic test_reset_mid();
        int k;
        fill_const(4'd15);
        res_ready_i = 1'b0;
        kick(4'b1111);
        k = 0;
        do begin
            @(negedge clk_i);
            k++;
        end while (!res_valid_o && k < 20);
        @(posedge clk_i); #1;
        start_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if (res_valid_o !== 1'b1 || res_idx_o !== 2'd0 || mem_req_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL start_in_emit valid=%0b idx=%0d req=%0b busy=%0b required 1 0 0 1",
                     res_valid_o, res_idx_o, mem_req_o, busy_o);
        end
        #2;
        rst_ni = 1'b0;
        #1;
        check_all_zero("async_reset");
        start_i = 1'b0;
        checks++;
        if (exp_q.size() != 4) begin
            errors++;
            $display("FAIL reset_pending got=%0d required=4", exp_q.size());
        end
        exp_q.delete();
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_all_zeros();
        test_back_to_back();
        test_stall();
        test_abort();
        test_reset_mid();
        repeat (2) @(negedge clk_i);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ising_field_scheduler
`default_nettype wire

// File: doc/ising_field_scheduler.md
# ising_field_scheduler

Sequencer that computes all local fields h_c = Σ_k (σ_k ? +J[k][c] : −J[k][c]) of an Ising problem, plus the total energy term E = Σ_c (σ_c ? +h_c : −h_c). It holds a spin vector and fetches one J column per step from a column-organised coupling memory. Each column passes through one internal DotProductTree instance, and each h_c is emitted on a valid/ready stream. It sits between the coupling-matrix SRAM and the spin-update logic of the annealer core.

## Interface
- VECTOR_SIZE, 256, spins per column / tree width (power of two, ≥2)
- J_ELEMENT_WIDTH, 4, unsigned magnitude width of one J element
- NUM_COLS, 256, columns per run (≥1, ≤VECTOR_SIZE)
- RESULT_WIDTH, J_ELEMENT_WIDTH+1+$clog2(VECTOR_SIZE), signed width of h_c
- ENERGY_WIDTH, RESULT_WIDTH+$clog2(NUM_COLS)+1, signed width of E

Ports:
- clk_i  in  1  clock; the single clock of the block
- rst_ni  in  1  reset, asynchronous, active-low
- start_i  in  1  start a run; sampled only in IDLE
- abort_i  in  1  synchronous abort; priority over every other input
- sigma_i  in  VECTOR_SIZE  spin vector; latched when start is accepted
- busy_o  out  1  run in progress
- done_o  out  1  one-cycle pulse when a run completes normally
- energy_o  out  ENERGY_WIDTH  signed E; valid from done_o and held until the next accepted start
- mem_req_o  out  1  column read request
- mem_addr_o  out  $clog2(NUM_COLS) (min 1)  column index
- mem_rdata_i  in  VECTOR_SIZE*J_ELEMENT_WIDTH  J column; element k at bits [k*Jw +: Jw]; valid exactly 1 cycle after mem_req_o
- res_valid_o  out  1  h_c available
- res_ready_i  in  1  consumer accepts
- res_data_o  out  RESULT_WIDTH  signed h_c
- res_idx_o  out  $clog2(NUM_COLS) (min 1)  column c of res_data_o

## Operation
- FSM states: IDLE, FETCH, CAPT, EMIT.
- IDLE: when start_i=1 and abort_i=0, latch sigma_i, clear the column counter and the energy accumulator, go to FETCH. start_i outside IDLE is ignored.
- FETCH: mem_req_o=1, mem_addr_o=counter, go to CAPT.
- CAPT: feed the latched σ and mem_rdata_i into the tree. Register the tree output into res_data_o and the counter into res_idx_o. Add ±h_c to the energy accumulator, with the sign taken from σ[counter]. Go to EMIT.
- EMIT: res_valid_o=1. res_data_o and res_idx_o are held stable until res_ready_i=1. On handshake:
  - If counter=NUM_COLS−1, go to IDLE and pulse done_o next cycle.
  - Otherwise increment the counter and go to FETCH.
- Arithmetic: h_c is sign-extended to ENERGY_WIDTH before accumulation. Negation is two's complement. There is no overflow possible at the given widths.
- abort_i=1 in any state: next state IDLE, res_valid_o drops, no done_o. energy_o keeps its previous value only if no start was accepted since; otherwise it reads 0.
- busy_o = (state ≠ IDLE).
- Reset (asynchronous, any time, including mid-run):
  - state IDLE.
  - All outputs 0: busy_o, done_o, mem_req_o, mem_addr_o, res_valid_o, res_data_o, res_idx_o, energy_o.
  - Latched σ cleared.

## Timing
- Start sampled at cycle t → mem_req_o at t+1 → data captured at t+2 → res_valid_o at t+3.
- With res_ready_i held high, a handshake at cycle u is followed by the next mem_req_o at u+1. This gives 3 cycles per column and 3·NUM_COLS cycles per run.
- done_o and busy_o=0 occur in the cycle after the final handshake. energy_o is updated by then; the final accumulation happens in the last CAPT.
- Back-to-back runs: the earliest new start is sampled in the done_o cycle.
- There is no combinational path from res_ready_i or mem_rdata_i to any output.

## Structure
- Shared package ising_pkg holds:
  - the FSM state enum (IDLE, FETCH, CAPT, EMIT);
  - width helper constants: RESULT_WIDTH and ENERGY_WIDTH formulas, the address-width function max(1,$clog2(n)).
- One sub-module: DotProductTree, instantiated once. Its J_col array is unpacked from mem_rdata_i.

## Test plan
- Config VECTOR_SIZE=4, Jw=4, NUM_COLS=4. σ=4'b1111, all J=15, ready=1 → h=60,60,60,60 with idx 0..3. E=240. done_o at cycle 13 after start.
- Same J, σ=4'b0000 → each h=−60. E=+240, since each column term is −(−60).
- σ=4'b0101, column c filled with value c+1 → h=0,0,0,0. E=0. Checks mixed signs and the element bit ordering.
- res_ready_i low for 5 cycles in the first EMIT → res_data_o and res_idx_o stable, no new mem_req_o, busy_o=1 throughout.
- abort_i at the second CAPT → IDLE next cycle, no done_o, no res_valid_o. A fresh start then completes normally with correct E.
- rst_ni low during EMIT → all outputs 0 asynchronously. start_i asserted in EMIT is ignored.
